// File: rtl/pong_pkg.sv
// Shared Pong definitions: state and winner encodings, BCD width, BCD helper.
package pong_pkg;

  localparam int unsigned BCD_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_PLAY  = 2'b01,
    ST_POINT = 2'b10,
    ST_OVER  = 2'b11
  } state_e;

  typedef enum logic [1:0] {
    WINNER_NONE = 2'b00,
    WINNER_P1   = 2'b01,
    WINNER_P2   = 2'b10
  } winner_e;

  // Two-digit BCD {tens, ones} to binary, 0..99.
  function automatic logic [6:0] bcd2bin(input logic [BCD_W-1:0] bcd);
    return 7'(bcd[7:4]) * 7'd10 + 7'(bcd[3:0]);
  endfunction

endpackage

// File: rtl/score_fsm_if.sv
// Bundle between the score FSM and its surroundings (ball, VGA timing, overlay).
interface score_fsm_if;
  import pong_pkg::*;

  logic             frame_tick;
  logic             miss1;
  logic             miss2;
  logic             serve;
  logic             ball_en;
  logic             ball_rst;
  logic [BCD_W-1:0] score1;
  logic [BCD_W-1:0] score2;
  logic [1:0]       state;
  logic [1:0]       winner;

  modport slave (
    input  frame_tick, miss1, miss2, serve,
    output ball_en, ball_rst, score1, score2, state, winner
  );

  modport master (
    output frame_tick, miss1, miss2, serve,
    input  ball_en, ball_rst, score1, score2, state, winner
  );

endinterface

// File: rtl/bcd_counter2.sv
// Two-digit BCD counter, 00..99 with wrap; clr has priority over inc.
module bcd_counter2
  import pong_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [BCD_W-1:0] count
);

  logic [BCD_W-1:0] count_q;
  logic [BCD_W-1:0] count_d;

  // Next value: clear, or increment ones with carry into tens (99 -> 00).
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc) begin
      if (count_q[3:0] == 4'd9) begin
        count_d[3:0] = 4'd0;
        count_d[7:4] = (count_q[7:4] == 4'd9) ? 4'd0 : count_q[7:4] + 4'd1;
      end else begin
        count_d[3:0] = count_q[3:0] + 4'd1;
      end
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/score_fsm.sv
// Pong game-flow controller: scores, serve/pause sequencing, ball gating.
// Optional feature macro: SCORE_GAME_OVER_EN enables win detection and OVER.
module score_fsm
  import pong_pkg::*;
#(
  parameter int unsigned WIN_SCORE    = 11,
  parameter int unsigned PAUSE_FRAMES = 60
) (
  input  logic        clk,
  input  logic        reset,
  score_fsm_if.slave  bus
);

`ifdef SCORE_GAME_OVER_EN
  localparam bit GAME_OVER_EN = 1'b1;
`else
  localparam bit GAME_OVER_EN = 1'b0;
`endif

  localparam logic [6:0] WIN_B      = 7'(WIN_SCORE);
  localparam logic [7:0] PAUSE_LAST = 8'(PAUSE_FRAMES - 1);

  state_e           state_q, state_d;
  winner_e          winner_q, winner_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             ball_en_q, ball_en_d;
  logic             ball_rst_q, ball_rst_d;
  logic             serve_q, rise_q, primed_q;
  logic             inc1, inc2, clr;
  logic             win1, win2;
  logic [BCD_W-1:0] score1, score2;

  bcd_counter2 u_score1 (
    .clk   (clk),
    .reset (reset),
    .clr   (clr),
    .inc   (inc1),
    .count (score1)
  );

  bcd_counter2 u_score2 (
    .clk   (clk),
    .reset (reset),
    .clr   (clr),
    .inc   (inc2),
    .count (score2)
  );

  assign win1 = bcd2bin(score1) >= WIN_B;
  assign win2 = bcd2bin(score2) >= WIN_B;

  // Serve edge detector, registered; primed_q masks the first cycle after
  // reset so a button held through reset does not count as a press.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      serve_q  <= 1'b0;
      rise_q   <= 1'b0;
      primed_q <= 1'b0;
    end else begin
      serve_q  <= bus.serve;
      rise_q   <= primed_q & bus.serve & ~serve_q;
      primed_q <= 1'b1;
    end
  end

  // Game flow: next state, pause counter, winner, score strobes, ball controls.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    winner_d   = winner_q;
    ball_rst_d = 1'b0;
    inc1       = 1'b0;
    inc2       = 1'b0;
    clr        = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (rise_q) begin
          state_d    = ST_PLAY;
          ball_rst_d = 1'b1;
        end
      end
      ST_PLAY: begin
        if (bus.miss1 | bus.miss2) begin
          inc1       = bus.miss2 & ~bus.miss1;
          inc2       = bus.miss1 & ~bus.miss2;
          cnt_d      = '0;
          state_d    = ST_POINT;
          ball_rst_d = 1'b1;
        end
      end
      ST_POINT: begin
        if (bus.frame_tick) begin
          if (cnt_q == PAUSE_LAST) begin
            cnt_d = '0;
            if (GAME_OVER_EN && (win1 || win2)) begin
              state_d  = ST_OVER;
              winner_d = win1 ? WINNER_P1 : WINNER_P2;
            end else begin
              state_d = ST_PLAY;
            end
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      ST_OVER: begin
        if (rise_q) begin
          clr        = 1'b1;
          winner_d   = WINNER_NONE;
          state_d    = ST_IDLE;
          ball_rst_d = 1'b1;
        end
      end
      default: ;
    endcase
    ball_en_d = (state_d == ST_PLAY);
  end

  // FSM and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      winner_q   <= WINNER_NONE;
      ball_en_q  <= 1'b0;
      ball_rst_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      winner_q   <= winner_d;
      ball_en_q  <= ball_en_d;
      ball_rst_q <= ball_rst_d;
    end
  end

  assign bus.ball_en  = ball_en_q;
  assign bus.ball_rst = ball_rst_q;
  assign bus.score1   = score1;
  assign bus.score2   = score2;
  assign bus.state    = state_q;
  assign bus.winner   = GAME_OVER_EN ? winner_q : WINNER_NONE;

endmodule

// File: tb/tb_score_fsm.sv
// Bench for score_fsm: directed table, corner sequences, randomized run
// against a behavioural game model.
module tb_score_fsm;

  localparam int unsigned PAUSE = 3;
  localparam int unsigned WIN   = 3;
`ifdef SCORE_GAME_OVER_EN
  localparam bit GO = 1'b1;
`else
  localparam bit GO = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  score_fsm_if bus();

  score_fsm #(.WIN_SCORE(WIN), .PAUSE_FRAMES(PAUSE)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Behavioural model: binary scores, phase code, frames left in the pause.
  int m_phase, m_s1, m_s2, m_win, m_left, m_age;
  bit m_rise, m_serve_prev, m_rst;

  typedef struct {
    logic       m1, m2, sv, tk;
    logic [1:0] st;
    logic       en, rst;
    logic [7:0] s1, s2;
  } vec_t;
  vec_t tbl[$];

  function automatic logic [7:0] bcd(input int v);
    logic [7:0] r;
    r = {4'(v / 10), 4'(v % 10)};
    return r;
  endfunction

  function automatic logic [21:0] mexp();
    return {(m_phase == 1), m_rst, bcd(m_s1), bcd(m_s2), 2'(m_phase), 2'(m_win)};
  endfunction

  function automatic logic [21:0] dut_vec();
    return {bus.ball_en, bus.ball_rst, bus.score1, bus.score2, bus.state, bus.winner};
  endfunction

  task automatic mreset();
    m_phase = 0; m_s1 = 0; m_s2 = 0; m_win = 0; m_left = 0; m_age = 0;
    m_rise = 0; m_serve_prev = 0; m_rst = 0;
  endtask

  task automatic mstep(input logic m1, input logic m2, input logic sv, input logic tk);
    bit rise_now;
    rise_now     = m_rise;
    m_rise       = (m_age >= 1) && sv && !m_serve_prev;
    m_serve_prev = sv;
    if (m_age < 2) m_age++;
    m_rst = 0;
    case (m_phase)
      0: if (rise_now) begin m_phase = 1; m_rst = 1; end
      1: if (m1 || m2) begin
           if (m1 && !m2) m_s2 = (m_s2 + 1) % 100;
           if (m2 && !m1) m_s1 = (m_s1 + 1) % 100;
           m_phase = 2; m_left = PAUSE; m_rst = 1;
         end
      2: if (tk) begin
           m_left--;
           if (m_left == 0) begin
             if (GO && (m_s1 >= WIN || m_s2 >= WIN)) begin
               m_phase = 3;
               m_win   = (m_s1 >= WIN) ? 1 : 2;
             end else begin
               m_phase = 1;
             end
           end
         end
      default: if (rise_now) begin
           m_s1 = 0; m_s2 = 0; m_win = 0; m_rst = 1; m_phase = 0;
         end
    endcase
  endtask

  task automatic chk(input string name, input logic [21:0] got, input logic [21:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got en=%b rst=%b s1=%h s2=%h st=%b win=%b, expected en=%b rst=%b s1=%h s2=%h st=%b win=%b",
               name, got[21], got[20], got[19:12], got[11:4], got[3:2], got[1:0],
               exp[21], exp[20], exp[19:12], exp[11:4], exp[3:2], exp[1:0]);
    end
  endtask

  task automatic chk8(input string name, input logic [7:0] got, input logic [7:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // One clock: drive inputs, step past the edge, compare against the model.
  task automatic cyc(input logic m1, input logic m2, input logic sv, input logic tk);
    bus.miss1 = m1; bus.miss2 = m2; bus.serve = sv; bus.frame_tick = tk;
    @(posedge clk);
    #1;
    if (!reset) mreset();
    else        mstep(m1, m2, sv, tk);
    chk("model", dut_vec(), mexp());
  endtask

  task automatic do_reset();
    reset = 1'b0;
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    reset = 1'b1;
    cyc(0, 0, 0, 0);
  endtask

  task automatic enter_play();
    cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 0, 0);
  endtask

  task automatic addv(input logic m1, input logic m2, input logic sv, input logic tk,
                      input logic [1:0] st, input logic en, input logic rst,
                      input logic [7:0] s1, input logic [7:0] s2);
    vec_t v;
    v.m1 = m1; v.m2 = m2; v.sv = sv; v.tk = tk;
    v.st = st; v.en = en; v.rst = rst; v.s1 = s1; v.s2 = s2;
    tbl.push_back(v);
  endtask

  initial begin
    logic sv_lvl;
    reset = 1'b0;
    bus.miss1 = 0; bus.miss2 = 0; bus.serve = 0; bus.frame_tick = 0;
    mreset();
    #2;
    chk("reset_values", dut_vec(), 22'h0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    reset = 1'b1;
    cyc(0, 0, 0, 0);

    //   m1 m2 sv tk  state  en rst  s1     s2
    addv(1, 0, 0, 0, 2'b00, 0, 0, 8'h00, 8'h00);  // miss in IDLE ignored
    addv(0, 0, 1, 0, 2'b00, 0, 0, 8'h00, 8'h00);  // serve edge registered
    addv(0, 0, 1, 0, 2'b01, 1, 1, 8'h00, 8'h00);  // enter PLAY with recentre
    addv(0, 0, 0, 0, 2'b01, 1, 0, 8'h00, 8'h00);
    addv(0, 1, 0, 0, 2'b10, 0, 1, 8'h01, 8'h00);  // player 1 scores
    addv(1, 0, 0, 0, 2'b10, 0, 0, 8'h01, 8'h00);  // miss in POINT ignored
    addv(0, 0, 0, 1, 2'b10, 0, 0, 8'h01, 8'h00);
    addv(0, 0, 0, 0, 2'b10, 0, 0, 8'h01, 8'h00);
    addv(0, 0, 0, 1, 2'b10, 0, 0, 8'h01, 8'h00);
    addv(0, 0, 0, 1, 2'b01, 1, 0, 8'h01, 8'h00);  // third tick ends pause
    addv(1, 1, 0, 0, 2'b10, 0, 1, 8'h01, 8'h00);  // double miss: no score
    addv(0, 0, 0, 1, 2'b10, 0, 0, 8'h01, 8'h00);
    addv(0, 0, 0, 1, 2'b10, 0, 0, 8'h01, 8'h00);
    addv(0, 0, 0, 1, 2'b01, 1, 0, 8'h01, 8'h00);
    addv(0, 0, 1, 0, 2'b01, 1, 0, 8'h01, 8'h00);  // serve ignored in PLAY
    addv(0, 0, 0, 0, 2'b01, 1, 0, 8'h01, 8'h00);
    addv(0, 0, 0, 1, 2'b01, 1, 0, 8'h01, 8'h00);  // tick outside POINT
    addv(1, 0, 0, 0, 2'b10, 0, 1, 8'h01, 8'h01);  // player 2 scores
    addv(0, 0, 0, 1, 2'b10, 0, 0, 8'h01, 8'h01);
    addv(0, 0, 0, 1, 2'b10, 0, 0, 8'h01, 8'h01);
    addv(0, 0, 0, 1, 2'b01, 1, 0, 8'h01, 8'h01);

    foreach (tbl[i]) begin
      cyc(tbl[i].m1, tbl[i].m2, tbl[i].sv, tbl[i].tk);
      chk($sformatf("table[%0d]", i), dut_vec(),
          {tbl[i].en, tbl[i].rst, tbl[i].s1, tbl[i].s2, tbl[i].st, 2'b00});
    end

`ifdef SCORE_GAME_OVER_EN
    do_reset();
    enter_play();
    for (int k = 0; k < 3; k++) begin
      cyc(1, 0, 0, 0);
      repeat (PAUSE) cyc(0, 0, 0, 1);
    end
    chk("game_over", dut_vec(), {1'b0, 1'b0, 8'h00, 8'h03, 2'b11, 2'b10});
    cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 0);
    chk("over_to_idle", dut_vec(), {1'b0, 1'b1, 8'h00, 8'h00, 2'b00, 2'b00});
    cyc(0, 0, 0, 0);
    chk8("idle_rst_low", {7'd0, bus.ball_rst}, 8'h00);
`else
    do_reset();
    enter_play();
    for (int k = 1; k <= 100; k++) begin
      cyc(0, 1, 0, 0);
      if (k == 9)   chk8("bcd_09", bus.score1, 8'h09);
      if (k == 10)  chk8("bcd_carry", bus.score1, 8'h10);
      if (k == 99)  chk8("bcd_99", bus.score1, 8'h99);
      if (k == 100) chk8("bcd_wrap", bus.score1, 8'h00);
      repeat (PAUSE) cyc(0, 0, 0, 1);
    end
    chk8("no_winner", {6'd0, bus.winner}, 8'h00);
`endif

    // Asynchronous reset while in POINT, checked before the next clock edge.
    do_reset();
    enter_play();
    cyc(1, 0, 0, 0);
    chk("pre_reset_point", dut_vec(), {1'b0, 1'b1, 8'h00, 8'h01, 2'b10, 2'b00});
    #2;
    reset = 1'b0;
    #1;
    chk("async_reset_mid_point", dut_vec(), 22'h0);
    mreset();
    cyc(0, 0, 0, 0);
    reset = 1'b1;
    cyc(0, 0, 0, 0);

    // Randomized play with occasional resets.
    sv_lvl = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 599) == 0) reset = 1'b0;
      else if (!reset)                 reset = 1'b1;
      if ($urandom_range(0, 4) == 0) sv_lvl = ~sv_lvl;
      cyc($urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0, sv_lvl,
          $urandom_range(0, 2) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
